fetch_decode_queue: RTL and testbench

//  Instruction queue between the fetch stage and decode (IF/ID boundary).

---
 rtl/fetch_decode_queue.sv | 158 +++++++++++++++
 tb/tb_fetch_decode_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: IF/ID instruction queue.
// Captures {instr, pc, pc+2, err} from fetch and presents the oldest entry to
// decode, absorbing decode back-pressure. A redirect (flush) empties the queue.
// When empty, a NOP bubble is presented. An entry flagged with a memory error is
// presented as HALT (16'h0000) with out_err set.
// Optional feature: define FDQ_STATS_EN to add the bubble_cycles and
// flushed_entries saturating statistics counters.
module fetch_decode_queue #(
  parameter int unsigned DEPTH     = 4,        // power of 2, >= 2
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [15:0]                  in_instr,
  input  logic [15:0]                  in_pc,
  input  logic [15:0]                  in_pc_plus_two,
  input  logic                         in_err,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [15:0]                  out_instr,
  output logic [15:0]                  out_pc,
  output logic [15:0]                  out_pc_plus_two,
  output logic                         out_err,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FDQ_STATS_EN
  ,
  output logic [15:0]                  bubble_cycles,
  output logic [15:0]                  flushed_entries
`endif
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [15:0]      HALT     = 16'h0000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus_two;
    logic        err;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Handshake status comes only from registered count, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  // Next-state for pointers and occupancy; flush wins over push and pop.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Entry storage written at the tail on each accepted fetch.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count gates out_valid,
    // so stale contents are never presented.
    if (push) begin
      mem_q[wr_q] <= '{instr: in_instr, pc: in_pc,
                       pc_plus_two: in_pc_plus_two, err: in_err};
    end
  end

  // Head presentation: NOP bubble when empty, HALT for an errored fetch.
  always_comb begin
    head            = mem_q[rd_q];
    out_instr       = NOP_INSTR;
    out_pc          = '0;
    out_pc_plus_two = '0;
    out_err         = 1'b0;
    if (out_valid) begin
      out_instr       = head.err ? HALT : head.instr;
      out_pc          = head.pc;
      out_pc_plus_two = head.pc_plus_two;
      out_err         = head.err;
    end
  end

`ifdef FDQ_STATS_EN
  logic [15:0] bubble_q, bubble_d;
  logic [15:0] flushed_q, flushed_d;
  logic [16:0] flushed_sum;

  // Saturating statistics: decode-starved cycles and entries lost to redirects.
  always_comb begin
    bubble_d    = bubble_q;
    flushed_d   = flushed_q;
    flushed_sum = {1'b0, flushed_q} + 17'(count_q);
    if (out_ready && !out_valid && !flush && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
    if (flush) begin
      flushed_d = flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q  <= '0;
      flushed_q <= '0;
    end else begin
      bubble_q  <= bubble_d;
      flushed_q <= flushed_d;
    end
  end

  assign bubble_cycles   = bubble_q;
  assign flushed_entries = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: table-driven vectors plus a
// scoreboard queue model, and hand-written reset / error / stats sequences.
// Define FDQ_STATS_EN to also cover the statistics counters.
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic [15:0] in_pc_plus_two;
  logic        in_err;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc_plus_two;
  logic        out_err;
  logic [2:0]  count;
`ifdef FDQ_STATS_EN
  logic [15:0] bubble_cycles;
  logic [15:0] flushed_entries;
`endif

  fetch_decode_queue #(.DEPTH(4), .NOP_INSTR(16'h0800)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .in_pc_plus_two  (in_pc_plus_two),
    .in_err          (in_err),
    .in_ready        (in_ready),
    .flush           (flush),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus_two (out_pc_plus_two),
    .out_err         (out_err),
    .count           (count)
`ifdef FDQ_STATS_EN
    ,
    .bubble_cycles   (bubble_cycles),
    .flushed_entries (flushed_entries)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc2;
    logic        err;
  } ent_t;

  typedef struct {
    logic        vld;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        ordy;
    logic        fl;
    int          exp_count;   // occupancy seen before the edge
    logic        exp_ready;
  } vec_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bubble_m = 0;
  int   flushed_m = 0;
  vec_t vecs[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, update model, advance.
  task automatic cycle(input logic vld, input logic [15:0] instr, input logic [15:0] pc,
                       input logic err, input logic ordy, input logic fl, input int tbl_cnt,
                       input logic tbl_rdy);
    ent_t e;
    logic ev;
    in_valid       = vld;
    in_instr       = instr;
    in_pc          = pc;
    in_pc_plus_two = pc + 16'd2;
    in_err         = err;
    out_ready      = ordy;
    flush          = fl;
    #4;
    ev = (exp_q.size() != 0);
    check("out_valid", 32'(out_valid), 32'(ev));
    check("count", 32'(count), 32'(exp_q.size()));
    check("in_ready", 32'(in_ready), 32'(exp_q.size() != 4));
    if (tbl_cnt >= 0) begin
      check("tbl_count", 32'(count), 32'(tbl_cnt));
      check("tbl_ready", 32'(in_ready), 32'(tbl_rdy));
    end
    if (ev) begin
      e = exp_q[0];
      check("out_instr", 32'(out_instr), 32'(e.err ? 16'h0000 : e.instr));
      check("out_pc", 32'(out_pc), 32'(e.pc));
      check("out_pc2", 32'(out_pc_plus_two), 32'(e.pc2));
      check("out_err", 32'(out_err), 32'(e.err));
    end else begin
      check("nop_instr", 32'(out_instr), 32'h0800);
      check("nop_pc", 32'(out_pc), 32'h0);
      check("nop_err", 32'(out_err), 32'h0);
    end
    if (fl) begin
      flushed_m = flushed_m + exp_q.size();
      if (flushed_m > 16'hFFFF) flushed_m = 16'hFFFF;
      exp_q.delete();
    end else begin
      if (ordy && !ev && bubble_m < 16'hFFFF) bubble_m++;
      if (ordy && ev) void'(exp_q.pop_front());
      if (vld && exp_q.size() + (ordy && ev ? 1 : 0) != 4) begin
        e.instr = instr;
        e.pc    = pc;
        e.pc2   = pc + 16'd2;
        e.err   = err;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fill-to-full, overflow attempt, drain; C123 latency; steady push+pop; flush.
    vecs[0]  = '{1'b1, 16'h1000, 16'd0,  1'b0, 1'b0, 0, 1'b1};
    vecs[1]  = '{1'b1, 16'h1002, 16'd2,  1'b0, 1'b0, 1, 1'b1};
    vecs[2]  = '{1'b1, 16'h1004, 16'd4,  1'b0, 1'b0, 2, 1'b1};
    vecs[3]  = '{1'b1, 16'h1006, 16'd6,  1'b0, 1'b0, 3, 1'b1};
    vecs[4]  = '{1'b1, 16'h1008, 16'd8,  1'b0, 1'b0, 4, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 16'd0,  1'b1, 1'b0, 4, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 16'd0,  1'b1, 1'b0, 3, 1'b1};
    vecs[7]  = '{1'b0, 16'h0000, 16'd0,  1'b1, 1'b0, 2, 1'b1};
    vecs[8]  = '{1'b0, 16'h0000, 16'd0,  1'b1, 1'b0, 1, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 16'd0,  1'b1, 1'b0, 0, 1'b1};
    vecs[10] = '{1'b1, 16'hC123, 16'd10, 1'b0, 1'b0, 0, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 16'd0,  1'b0, 1'b0, 1, 1'b1};
    vecs[12] = '{1'b1, 16'h2012, 16'd12, 1'b0, 1'b0, 1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      vecs[13+i] = '{1'b1, 16'h2000 + 16'(14 + 2*i), 16'(14 + 2*i), 1'b1, 1'b0, 2, 1'b1};
    end
    vecs[23] = '{1'b0, 16'h0000, 16'd0,  1'b0, 1'b0, 2, 1'b1};
    vecs[24] = '{1'b1, 16'h3000, 16'h30, 1'b0, 1'b0, 2, 1'b1};
    vecs[25] = '{1'b1, 16'hDEAD, 16'h40, 1'b0, 1'b1, 3, 1'b1};
    vecs[26] = '{1'b0, 16'h0000, 16'd0,  1'b0, 1'b0, 0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_pc_plus_two = '0;
    in_err = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_count", 32'(count), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    check("rst_instr", 32'(out_instr), 32'h0800);
    check("rst_pc2", 32'(out_pc_plus_two), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) begin
      cycle(vecs[i].vld, vecs[i].instr, vecs[i].pc, 1'b0, vecs[i].ordy, vecs[i].fl,
            vecs[i].exp_count, vecs[i].exp_ready);
    end
`ifdef FDQ_STATS_EN
    check("flushed_entries", 32'(flushed_entries), 32'(flushed_m));
    check("flushed_is_3", 32'(flushed_entries), 32'd3);
    check("bubble_model", 32'(bubble_cycles), 32'(bubble_m));
`endif

    // Asynchronous reset mid-cycle with three entries held.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h4000 + 16'(i), 16'(16'h60 + 2*i), 1'b0, 1'b0, 1'b0, -1, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("pre_rst_count", 32'(count), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_instr", 32'(out_instr), 32'h0800);
    check("arst_ready", 32'(in_ready), 32'h1);
    exp_q.delete();
    bubble_m = 0;
    flushed_m = 0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Errored fetch presented as HALT, then popped; then five starved cycles.
    cycle(1'b1, 16'h1234, 16'h50, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    check("err_flag", 32'(out_err), 32'h1);
    check("err_halt", 32'(out_instr), 32'h0000);
    cycle(1'b0, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    check("err_cleared", 32'(out_err), 32'h0);
`ifdef FDQ_STATS_EN
    check("bubble_is_5", 32'(bubble_cycles), 32'd5);
    check("bubble_model2", 32'(bubble_cycles), 32'(bubble_m));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
